// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and load/store (D) misses onto one multi-cycle memory port.
// Optional round-robin arbitration on simultaneous requests: define MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              owner_d,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              owner_q;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              grant_d;
  logic              any_req;
  logic              timed_out;

  assign any_req   = i_req | d_req;
  assign timed_out = (cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On a tie the side that was not served last wins.
  assign grant_d = d_req & ~(i_req & last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= grant_d;
    end
  end
`else
  // D is the older instruction, so it wins every tie.
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: state and datapath registers use non-blocking assignments so every
      // flop samples pre-edge values regardless of process ordering.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (mem_valid || timed_out) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner_q <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            wr_q    <= grant_d & d_wr;
            wdata_q <= grant_d ? d_wdata : '0;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (mem_valid || timed_out) begin
            // Writes and timeouts both return zero data to the requester.
            if (owner_q) begin
              d_rdata_q <= (mem_valid && !wr_q) ? mem_rdata : '0;
            end else begin
              i_rdata_q <= (mem_valid && !wr_q) ? mem_rdata : '0;
            end
            if (!mem_valid) err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state == RESP) & ~owner_q;
  assign d_ack     = (state == RESP) & owner_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != IDLE);
  assign owner_d   = owner_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Honours MEM_ARB_RR_EN when the same define is given to the whole build.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, mem_en, mem_wr, busy, owner_d, err;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .owner_d(owner_d), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    int            gap;
    logic          drop;
  } item_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  item_t iq[$], dq[$];
  logic i_out = 0, d_out = 0, i_drop = 0, d_drop = 0;
  int i_gap = 0, d_gap = 0;
  logic [DW-1:0] mem_img [logic [AW-1:0]];
  int fix_lat = 1;
  logic noise_en = 0;
  logic r_pend = 0;
  int r_left = 0;
  logic [DW-1:0] r_data = '0;

  // Transaction-level model state
  logic m_active = 0, m_prev_active = 0, m_side = 0, m_to = 0, m_last_d = 0, m_err = 0;
  int m_ack_cyc = 0;
  logic [DW-1:0] m_data = '0, m_i_rdata = '0, m_d_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  logic grant_log[$];
  int n_en = 0, obs_i_acks = 0, obs_d_acks = 0, i_ack_cyc = 0, d_ack_cyc = 0;
  logic last_wr = 0;
  logic [DW-1:0] last_wdata = '0;

  function automatic logic [DW-1:0] mem_read(logic [AW-1:0] a);
    return mem_img.exists(a) ? mem_img[a] : (a ^ 16'hC35A);
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev_active = 0; m_last_d = 0; m_err = 0;
    m_i_rdata = '0; m_d_rdata = '0;
    r_pend = 0; mem_valid = 0;
  endtask

  // One clock: drive memory, compare DUT against model, advance requesters.
  task automatic step();
    logic s_i, s_d, s_dwr, side, exp_en, ack_now, e_wr;
    logic [AW-1:0] s_ia, s_da, e_addr;
    logic [DW-1:0] s_dwd;
    int lat;
    item_t it;
    s_i = i_req; s_d = d_req; s_ia = i_addr; s_da = d_addr; s_dwr = d_wr; s_dwd = d_wdata;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      n_chk++;
      if ({i_ack, d_ack, mem_en, mem_wr, busy, owner_d, err, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
        n_fail++; $display("FAIL reset_outputs cyc=%0d got nonzero outputs", cyc);
      end
      model_reset();
      return;
    end
    mem_valid = 1'b0;
    if (r_pend) begin
      if (r_left == 1) begin mem_valid = 1'b1; mem_rdata = r_data; r_pend = 0; end
      else r_left--;
    end else if (noise_en && (!busy || mem_en || i_ack || d_ack)) begin
      mem_valid = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
    end
    if (i_ack) begin obs_i_acks++; i_ack_cyc = cyc; end
    if (d_ack) begin obs_d_acks++; d_ack_cyc = cyc; end

    exp_en = !m_prev_active && (s_i || s_d);
    n_chk++;
    if (mem_en !== exp_en) begin
      n_fail++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", cyc, mem_en, exp_en);
    end
    if (mem_en === 1'b1) begin
      n_en++;
      side = s_d && !(s_i && RR && m_last_d);
      m_last_d = side;
      grant_log.push_back(side);
      e_addr = side ? s_da : s_ia;
      e_wr = side & s_dwr;
      n_chk++;
      if (owner_d !== side || mem_addr !== e_addr || mem_wr !== e_wr ||
          (e_wr && mem_wdata !== s_dwd)) begin
        n_fail++;
        $display("FAIL command cyc=%0d got own=%b addr=%h wr=%b wd=%h exp own=%b addr=%h wr=%b wd=%h",
                 cyc, owner_d, mem_addr, mem_wr, mem_wdata, side, e_addr, e_wr, s_dwd);
      end
      last_wr = mem_wr; last_wdata = mem_wdata;
      lat = (fix_lat > 0) ? fix_lat : (fix_lat == -1) ? -1 :
            (($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TO)));
      m_side = side; m_addr = e_addr; m_active = 1;
      if (lat < 0) begin
        m_to = 1; m_data = '0; m_ack_cyc = cyc + TO + 1;
      end else begin
        m_to = 0; m_ack_cyc = cyc + lat + 1;
        m_data = e_wr ? '0 : mem_read(e_addr);
        r_pend = 1; r_left = lat; r_data = mem_read(mem_addr);
      end
      if (e_wr) mem_img[mem_addr] = mem_wdata;
      if (!side && i_drop) begin i_req = 0; i_addr = AW'($urandom); end
      if (side && d_drop) begin d_req = 0; d_addr = AW'($urandom); d_wdata = DW'($urandom); d_wr = ~d_wr; end
    end

    ack_now = m_active && (cyc == m_ack_cyc);
    n_chk++;
    if (i_ack !== (ack_now && !m_side) || d_ack !== (ack_now && m_side)) begin
      n_fail++; $display("FAIL ack cyc=%0d got i=%b d=%b exp i=%b d=%b", cyc, i_ack, d_ack,
                         ack_now && !m_side, ack_now && m_side);
    end
    if (ack_now) begin
      if (m_side) m_d_rdata = m_data; else m_i_rdata = m_data;
      if (m_to) m_err = 1;
      n_chk++;
      if (mem_addr !== m_addr) begin
        n_fail++; $display("FAIL mem_addr_hold cyc=%0d got=%h exp=%h", cyc, mem_addr, m_addr);
      end
    end
    n_chk++;
    if (i_rdata !== m_i_rdata || d_rdata !== m_d_rdata) begin
      n_fail++; $display("FAIL rdata cyc=%0d got i=%h d=%h exp i=%h d=%h", cyc, i_rdata, d_rdata,
                         m_i_rdata, m_d_rdata);
    end
    n_chk++;
    if (err !== m_err || busy !== m_active) begin
      n_fail++; $display("FAIL err_busy cyc=%0d got err=%b busy=%b exp err=%b busy=%b", cyc, err,
                         busy, m_err, m_active);
    end
    m_prev_active = m_active;
    if (ack_now) m_active = 0;

    if (ack_now && !m_side) begin i_out = 0; i_req = 0; end
    if (ack_now && m_side) begin d_out = 0; d_req = 0; end
    if (!i_out) begin
      if (i_gap > 0) i_gap--;
      else if (iq.size() > 0) begin
        it = iq.pop_front();
        i_req = 1; i_addr = it.addr; i_gap = it.gap; i_drop = it.drop; i_out = 1;
      end
    end
    if (!d_out) begin
      if (d_gap > 0) d_gap--;
      else if (dq.size() > 0) begin
        it = dq.pop_front();
        d_req = 1; d_addr = it.addr; d_wr = it.wr; d_wdata = it.wdata;
        d_gap = it.gap; d_drop = it.drop; d_out = 1;
      end
    end
  endtask

  task automatic run_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((m_active || i_out || d_out || iq.size() > 0 || dq.size() > 0) && n < max_cyc);
    n_chk++;
    if (m_active || i_out || d_out || iq.size() > 0 || dq.size() > 0) begin
      n_fail++; $display("FAIL drain_timeout got=busy_after_%0d_cycles exp=idle", n);
    end
  endtask

  function automatic item_t mk(logic [AW-1:0] a, logic w, logic [DW-1:0] wd, int g, logic dr);
    item_t it;
    it.addr = a; it.wr = w; it.wdata = wd; it.gap = g; it.drop = dr;
    return it;
  endfunction

  task automatic test_reset();
    rst_n = 0;
    repeat (3) step();
    n_chk++;
    if ({i_ack, d_ack, mem_en, busy, err, owner_d} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state got=%b exp=000000", {i_ack, d_ack, mem_en, busy, err, owner_d});
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_i_read();
    int en0, da0;
    en0 = n_en; da0 = obs_d_acks;
    mem_img[16'h0010] = 16'hA5A5;
    fix_lat = 3;
    iq.push_back(mk(16'h0010, 0, '0, 0, 0));
    run_idle(50);
    n_chk++;
    if (n_en - en0 != 1 || i_rdata !== 16'hA5A5 || obs_d_acks != da0) begin
      n_fail++; $display("FAIL i_read got en=%0d rdata=%h dacks=%0d exp en=1 rdata=a5a5 dacks=0",
                         n_en - en0, i_rdata, obs_d_acks - da0);
    end
  endtask

  task automatic test_collision();
    int en0;
    en0 = n_en;
    grant_log.delete();
    fix_lat = 1;
    dq.push_back(mk(16'h0200, 0, '0, 0, 0));
    iq.push_back(mk(16'h0300, 0, '0, 0, 0));
    run_idle(50);
    n_chk++;
    if (n_en - en0 != 2 || grant_log.size() != 2 || grant_log[0] !== 1'b1 ||
        i_ack_cyc - d_ack_cyc < 4) begin
      n_fail++; $display("FAIL collision got en=%0d gap=%0d exp en=2 gap>=4 d_first", n_en - en0,
                         i_ack_cyc - d_ack_cyc);
    end
  endtask

  task automatic test_d_write();
    fix_lat = 2;
    dq.push_back(mk(16'h0100, 1, 16'h1234, 0, 0));
    run_idle(50);
    n_chk++;
    if (last_wr !== 1'b1 || last_wdata !== 16'h1234 || d_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL d_write got wr=%b wd=%h rd=%h exp wr=1 wd=1234 rd=0000", last_wr,
                         last_wdata, d_rdata);
    end
    dq.push_back(mk(16'h0100, 0, '0, 0, 0));
    run_idle(50);
    n_chk++;
    if (d_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL d_readback got=%h exp=1234", d_rdata);
    end
  endtask

  task automatic test_timeout();
    int ia0;
    fix_lat = -1;
    ia0 = obs_i_acks;
    iq.push_back(mk(16'h0042, 0, '0, 0, 0));
    run_idle(50);
    n_chk++;
    if (err !== 1'b1 || i_rdata !== '0 || obs_i_acks - ia0 != 1) begin
      n_fail++; $display("FAIL timeout got err=%b rd=%h acks=%0d exp err=1 rd=0 acks=1", err, i_rdata,
                         obs_i_acks - ia0);
    end
    fix_lat = TO;
    iq.push_back(mk(16'h0044, 0, '0, 0, 0));
    run_idle(50);
    n_chk++;
    if (err !== 1'b1 || i_rdata !== mem_read(16'h0044)) begin
      n_fail++; $display("FAIL late_valid got err=%b rd=%h exp err=1 rd=%h", err, i_rdata,
                         mem_read(16'h0044));
    end
  endtask

  task automatic test_reset_mid();
    int ia0;
    fix_lat = -1;
    iq.push_back(mk(16'h0050, 0, '0, 0, 0));
    repeat (4) step();
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({i_ack, d_ack, mem_en, mem_wr, busy, owner_d, err, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid got busy=%b addr=%h exp all zero", busy, mem_addr);
    end
    i_req = 0; i_out = 0; i_gap = 0; iq.delete();
    step();
    rst_n = 1;
    ia0 = obs_i_acks;
    repeat (4) step();
    n_chk++;
    if (obs_i_acks != ia0) begin
      n_fail++; $display("FAIL ack_after_reset got=%0d exp=0", obs_i_acks - ia0);
    end
    fix_lat = 2;
    iq.push_back(mk(16'h0060, 0, '0, 0, 0));
    run_idle(50);
  endtask

  task automatic test_round_robin();
    logic [3:0] got, exp;
    grant_log.delete();
    fix_lat = 1;
    for (int k = 0; k < 4; k++) begin
      dq.push_back(mk(AW'(16'h0400 + k), 0, '0, 0, 0));
      iq.push_back(mk(AW'(16'h0500 + k), 0, '0, 0, 0));
    end
    run_idle(100);
    got = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
    exp = RR ? 4'b1010 : 4'b1111;
    n_chk++;
    if (got !== exp) begin
      n_fail++; $display("FAIL grant_order got=%b exp=%b (1=D)", got, exp);
    end
  endtask

  task automatic test_random();
    fix_lat = 0;
    noise_en = 1;
    for (int k = 0; k < 40; k++) begin
      iq.push_back(mk(AW'($urandom_range(0, 15)), 0, '0, int'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0));
      dq.push_back(mk(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), DW'($urandom),
                      int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0));
    end
    run_idle(3000);
    noise_en = 0;
    mem_valid = 0;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_collision();
    test_d_write();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
